// File: rtl/rtype_inst_writer_if.sv
// Request and instruction-memory write bus of the R-type instruction writer.
// The master modport is the writer itself; the slave modport is its environment.
interface rtype_inst_writer_if #(parameter int ADDR_W = 6);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_op;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [4:0]        shamt;
    logic              restart;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   words_written;
    logic              mem_full;

    modport master (
        input  in_valid, alu_op, rs_addr, rt_addr, rd_addr, shamt, restart, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, words_written, mem_full
    );
    modport slave (
        output in_valid, alu_op, rs_addr, rt_addr, rd_addr, shamt, restart, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, words_written, mem_full
    );
endinterface

// File: rtl/rtype_inst_writer.sv
// Encodes R-type requests into MIPS words, queues them and writes them to consecutive
// instruction-memory addresses. Define INST_WR_WRAP_EN to wrap the address instead of stopping.
module rtype_inst_writer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input logic                 clk,
    input logic                 rst,
    rtype_inst_writer_if.master wr_if
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]       FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WW_MAX   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    // Inverse of the datapath ALU_OP decode
    function automatic logic [5:0] funct_of(input logic [2:0] op);
        case (op)
            3'b100: return 6'b100000;
            3'b101: return 6'b100010;
            3'b000: return 6'b100100;
            3'b001: return 6'b100101;
            3'b010: return 6'b100110;
            3'b011: return 6'b100111;
            3'b110: return 6'b101011;
            3'b111: return 6'b000100;
        endcase
    endfunction

    logic [31:0]       fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       cnt_q, cnt_d;
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   ww_q;
    logic [31:0]       word_d;
    logic              push, pop, we;

    assign word_d = {6'b000000, wr_if.rs_addr, wr_if.rt_addr, wr_if.rd_addr,
                     wr_if.shamt, funct_of(wr_if.alu_op)};

    assign wr_if.in_ready = (cnt_q != FULL_CNT);
    assign push = wr_if.in_valid && wr_if.in_ready;
    // A restart cycle never completes a write
    assign we   = (state_q == WRITE) && !wr_if.restart;
    assign pop  = we && wr_if.mem_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= word_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

`ifdef INST_WR_WRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ww_q    <= '0;
        end else if (wr_if.restart) begin
            addr_q  <= '0;
            ww_q    <= '0;
            state_q <= (cnt_d != '0) ? WRITE : IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cnt_d != '0) state_q <= WRITE;
                WRITE: if (pop) begin
                    addr_q  <= addr_q + 1'b1;
                    if (ww_q != WW_MAX) ww_q <= ww_q + 1'b1;
                    state_q <= (cnt_d != '0) ? WRITE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_if.mem_full = 1'b0;
`else
    logic full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ww_q    <= '0;
            full_q  <= 1'b0;
        end else if (wr_if.restart) begin
            addr_q  <= '0;
            ww_q    <= '0;
            full_q  <= 1'b0;
            state_q <= (cnt_d != '0) ? WRITE : IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cnt_d != '0) state_q <= WRITE;
                WRITE: if (pop) begin
                    ww_q <= ww_q + 1'b1;
                    // Last address: park there until restart
                    if (addr_q == ADDR_MAX) begin
                        full_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= (cnt_d != '0) ? WRITE : IDLE;
                    end
                end
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_if.mem_full = full_q;
`endif

    assign wr_if.mem_we        = we;
    assign wr_if.mem_addr      = addr_q;
    assign wr_if.mem_wdata     = (state_q == WRITE) ? fifo_q[rd_ptr_q] : 32'h0;
    assign wr_if.words_written = ww_q;
endmodule

// File: tb/tb_rtype_inst_writer.sv
// Bench for rtype_inst_writer: vector table, directed corner sequences and a randomized
// run against a queue-based reference model; honours INST_WR_WRAP_EN.
module tb_rtype_inst_writer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rtype_inst_writer_if #(.ADDR_W(6)) ifa ();
    rtype_inst_writer_if #(.ADDR_W(2)) ifb ();

    rtype_inst_writer #(.DEPTH(4), .ADDR_W(6)) dut_a (.clk(clk), .rst(rst), .wr_if(ifa));
    rtype_inst_writer #(.DEPTH(4), .ADDR_W(2)) dut_b (.clk(clk), .rst(rst), .wr_if(ifb));

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] s, t, d, h);
        logic [5:0] f;
        case (op)
            3'd4:    f = 6'h20;
            3'd5:    f = 6'h22;
            3'd0:    f = 6'h24;
            3'd1:    f = 6'h25;
            3'd2:    f = 6'h26;
            3'd3:    f = 6'h27;
            3'd6:    f = 6'h2B;
            default: f = 6'h04;
        endcase
        return {6'b0, s, t, d, h, f};
    endfunction

    task automatic drv_a(input logic v, input logic [2:0] op, input logic [4:0] s, t, d, h);
        ifa.in_valid = v; ifa.alu_op = op;
        ifa.rs_addr = s; ifa.rt_addr = t; ifa.rd_addr = d; ifa.shamt = h;
    endtask

    task automatic drv_b(input logic v, input logic [2:0] op, input logic [4:0] s, t, d, h);
        ifb.in_valid = v; ifb.alu_op = op;
        ifb.rs_addr = s; ifb.rt_addr = t; ifb.rd_addr = d; ifb.shamt = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_in_ready"}, 32'(ifa.in_ready), 32'd1);
        chk({tag, "_we"},       32'(ifa.mem_we), 32'd0);
        chk({tag, "_addr"},     32'(ifa.mem_addr), 32'd0);
        chk({tag, "_wdata"},    ifa.mem_wdata, 32'd0);
        chk({tag, "_ww"},       32'(ifa.words_written), 32'd0);
        chk({tag, "_full"},     32'(ifa.mem_full), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t        vt[11];
        logic [31:0] sw[5];
        logic [31:0] wb[5];
        logic [31:0] q[$];
        int          got;
        logic        acc;
        int          addr_m, ww_m;
        logic        full_m;

        drv_a(0, 0, 0, 0, 0, 0); ifa.restart = 0; ifa.mem_ready = 0;
        drv_b(0, 0, 0, 0, 0, 0); ifb.restart = 0; ifb.mem_ready = 0;

        // Reset values
        rst = 1'b1;
        #1;
        chk_reset_a("rst");
        do_reset();

        // Single request, then back to idle
        ifa.mem_ready = 1;
        drv_a(1, 3'b100, 5'd1, 5'd2, 5'd3, 5'd0);
        @(posedge clk); #1;
        chk("one_we", 32'(ifa.mem_we), 32'd1);
        chk("one_addr", 32'(ifa.mem_addr), 32'd0);
        chk("one_wdata", ifa.mem_wdata, 32'h00221820);
        @(negedge clk); ifa.in_valid = 0;
        @(posedge clk); #1;
        chk("one_ww", 32'(ifa.words_written), 32'd1);
        chk("one_idle_we", 32'(ifa.mem_we), 32'd0);
        chk("one_idle_wdata", ifa.mem_wdata, 32'd0);

        // Vector table: op sweep then mixed fields, back to back
        vt[0]  = '{3'b100, 0, 0, 0, 0, 32'h00000020};
        vt[1]  = '{3'b101, 0, 0, 0, 0, 32'h00000022};
        vt[2]  = '{3'b000, 0, 0, 0, 0, 32'h00000024};
        vt[3]  = '{3'b001, 0, 0, 0, 0, 32'h00000025};
        vt[4]  = '{3'b010, 0, 0, 0, 0, 32'h00000026};
        vt[5]  = '{3'b011, 0, 0, 0, 0, 32'h00000027};
        vt[6]  = '{3'b110, 0, 0, 0, 0, 32'h0000002B};
        vt[7]  = '{3'b111, 0, 0, 0, 0, 32'h00000004};
        vt[8]  = '{3'b100, 1, 2, 3, 0, 32'h00221820};
        vt[9]  = '{3'b111, 31, 31, 31, 31, 32'h03FFFFC4};
        vt[10] = '{3'b110, 5, 6, 7, 3, 32'h00A638EB};
        do_reset();
        ifa.mem_ready = 1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drv_a(1, vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_we", i), 32'(ifa.mem_we), 32'd1);
            chk($sformatf("vec%0d_addr", i), 32'(ifa.mem_addr), 32'(i));
            chk($sformatf("vec%0d_wdata", i), ifa.mem_wdata, vt[i].exp);
        end
        @(negedge clk); ifa.in_valid = 0;
        @(posedge clk); #1;
        chk("vec_ww", 32'(ifa.words_written), 32'd11);
        chk("vec_we_end", 32'(ifa.mem_we), 32'd0);

        // Stalled memory: FIFO fills, fifth request held off
        do_reset();
        ifa.mem_ready = 0;
        for (int k = 0; k < 5; k++) sw[k] = enc(3'(k), 5'(k+1), 5'(k+2), 5'(k+3), 5'(k));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drv_a(1, 3'(k), 5'(k+1), 5'(k+2), 5'(k+3), 5'(k));
            @(posedge clk); #1;
            chk($sformatf("stall%0d_in_ready", k), 32'(ifa.in_ready), (k < 3) ? 32'd1 : 32'd0);
            chk($sformatf("stall%0d_wdata", k), ifa.mem_wdata, sw[0]);
            chk($sformatf("stall%0d_addr", k), 32'(ifa.mem_addr), 32'd0);
        end
        @(negedge clk);
        ifa.mem_ready = 1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            #1;
            if (ifa.mem_we && ifa.mem_ready) begin
                chk($sformatf("drain%0d_addr", got), 32'(ifa.mem_addr), 32'(got));
                chk($sformatf("drain%0d_wdata", got), ifa.mem_wdata, sw[got]);
                got++;
            end
            acc = ifa.in_valid && ifa.in_ready;
            @(posedge clk); @(negedge clk);
            if (acc) ifa.in_valid = 0;
        end
        chk("drain_count", 32'(got), 32'd5);
        ifa.in_valid = 0;

        // Small memory: end of address space
        do_reset();
        ifb.mem_ready = 1;
        for (int k = 0; k < 5; k++) wb[k] = enc(3'(k+2), 5'(k), 5'(k+9), 5'(k+20), 5'(k+1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drv_b(1, 3'(k+2), 5'(k), 5'(k+9), 5'(k+20), 5'(k+1));
            @(posedge clk); #1;
            if (k < 4) begin
                chk($sformatf("small%0d_we", k), 32'(ifb.mem_we), 32'd1);
                chk($sformatf("small%0d_addr", k), 32'(ifb.mem_addr), 32'(k));
                chk($sformatf("small%0d_wdata", k), ifb.mem_wdata, wb[k]);
            end
        end
        chk("small_ww4", 32'(ifb.words_written), 32'd4);
`ifdef INST_WR_WRAP_EN
        chk("wrap_we", 32'(ifb.mem_we), 32'd1);
        chk("wrap_addr", 32'(ifb.mem_addr), 32'd0);
        chk("wrap_wdata", ifb.mem_wdata, wb[4]);
        @(negedge clk); ifb.in_valid = 0;
        @(posedge clk); #1;
        chk("wrap_ww_sat", 32'(ifb.words_written), 32'd4);
        chk("wrap_full", 32'(ifb.mem_full), 32'd0);
        chk("wrap_addr1", 32'(ifb.mem_addr), 32'd1);
        chk("wrap_idle", 32'(ifb.mem_we), 32'd0);
`else
        chk("full_flag", 32'(ifb.mem_full), 32'd1);
        chk("full_we", 32'(ifb.mem_we), 32'd0);
        chk("full_addr", 32'(ifb.mem_addr), 32'd3);
        @(negedge clk); ifb.in_valid = 0;
        @(posedge clk); #1;
        chk("full_hold", 32'(ifb.mem_full), 32'd1);
        chk("full_in_ready", 32'(ifb.in_ready), 32'd1);
        @(negedge clk); ifb.restart = 1;
        #1;
        chk("restart_we", 32'(ifb.mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk); ifb.restart = 0;
        #1;
        chk("rewrite_we", 32'(ifb.mem_we), 32'd1);
        chk("rewrite_addr", 32'(ifb.mem_addr), 32'd0);
        chk("rewrite_wdata", ifb.mem_wdata, wb[4]);
        chk("rewrite_full", 32'(ifb.mem_full), 32'd0);
        chk("rewrite_ww0", 32'(ifb.words_written), 32'd0);
        @(posedge clk); #1;
        chk("rewrite_ww1", 32'(ifb.words_written), 32'd1);
`endif
        ifb.in_valid = 0;

        // Reset during a stalled write with three words queued
        do_reset();
        ifa.mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drv_a(1, 3'(k), 5'(k), 5'(k), 5'(k), 5'(k));
            @(posedge clk);
        end
        @(negedge clk); ifa.in_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk_reset_a("midrst");
        @(negedge clk); rst = 1'b0; ifa.mem_ready = 1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst%0d_we", c), 32'(ifa.mem_we), 32'd0);
            chk($sformatf("postrst%0d_ww", c), 32'(ifa.words_written), 32'd0);
        end

        // Randomized run against the queue model
        do_reset();
        q.delete();
        addr_m = 0; ww_m = 0; full_m = 1'b0;
        for (int c = 0; c < 500; c++) begin
            logic        iv, mr, rs, we_e, push;
            logic [31:0] w;
            logic [2:0]  op;
            logic [4:0]  f1, f2, f3, f4;
            @(negedge clk);
            iv = ($urandom_range(2) != 0);
            mr = ($urandom_range(1) != 0);
            rs = ($urandom_range(49) == 0);
            op = 3'($urandom); f1 = 5'($urandom); f2 = 5'($urandom);
            f3 = 5'($urandom); f4 = 5'($urandom);
            drv_a(iv, op, f1, f2, f3, f4);
            ifa.mem_ready = mr; ifa.restart = rs;
            w = enc(op, f1, f2, f3, f4);
            #1;
            we_e = (q.size() != 0) && !full_m && !rs;
            chk("rnd_in_ready", 32'(ifa.in_ready), 32'(q.size() < 4));
            chk("rnd_we", 32'(ifa.mem_we), 32'(we_e));
            chk("rnd_addr", 32'(ifa.mem_addr), 32'(addr_m));
            chk("rnd_ww", 32'(ifa.words_written), 32'(ww_m));
            chk("rnd_full", 32'(ifa.mem_full), 32'(full_m));
            if (we_e) chk("rnd_wdata", ifa.mem_wdata, q[0]);
            else if (q.size() == 0) chk("rnd_wdata_idle", ifa.mem_wdata, 32'd0);
            push = iv && (q.size() < 4);
            if (rs) begin
                addr_m = 0; ww_m = 0; full_m = 1'b0;
            end else if (we_e && mr) begin
                void'(q.pop_front());
                if (ww_m < 64) ww_m++;
                if (addr_m == 63) begin
`ifdef INST_WR_WRAP_EN
                    addr_m = 0;
`else
                    full_m = 1'b1;
`endif
                end else addr_m++;
            end
            if (push) q.push_back(w);
            @(posedge clk);
        end
        @(negedge clk);
        ifa.restart = 0; ifa.in_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
